// File: rtl/mul7_result_accumulator_pkg.sv
// Shared types and helpers for the 7*num1*num2 result accumulator.
// Latency: n/a (types, parameters and a combinational helper only).
// Backpressure: n/a.
package mul7_result_accumulator_pkg;

  typedef enum logic {S_RUN, S_HOLD} state_t;

  localparam int DEF_PROD_W = 43;
  localparam int DEF_ACC_W  = 48;

  // Widest accumulator the saturating helper supports.
  localparam int MAX_W = 64;

  // Unsigned add of two w-bit values held in MAX_W-bit containers.
  // Without overflow the plain sum is returned, so bit w is 0.
  // On overflow bits [w:0] are all ones: bit w flags the saturation and
  // the low w bits carry the saturated sum.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int unsigned      w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (MAX_W+1)'(1) << w;
    if (s >= lim) s = lim | (lim - (MAX_W+1)'(1));
    return s;
  endfunction

endpackage

// File: rtl/mul7_result_accumulator_sat_adder.sv
// Saturating unsigned ACC_W-bit adder.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (operands); sum (a+b clamped to all ones); sat (clamp occurred).
module sat_adder
  import mul7_result_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [MAX_W:0] r;

  assign r   = sat_add(MAX_W'(a), MAX_W'(b), ACC_W);
  assign sum = r[ACC_W-1:0];
  // Any bit at or above ACC_W means the true sum did not fit.
  assign sat = |r[MAX_W:ACC_W];

endmodule

// File: rtl/mul7_result_accumulator.sv
// Sums FRAME_LEN products per frame (or fewer on flush) into a one-entry output register.
// Latency: the frame result is visible right after the edge that accepts its last beat/flush, or one edge after drain when held.
// Backpressure: in_ready drops only when the output is full and the next beat would close a frame, or while a flushed frame is held.
// Ports: clk, rst_n; in_valid/in_data/in_ready product input; flush closes a partial frame;
//        out_valid/out_ready handshake with out_sum (saturated), out_count, out_ovf.
module mul7_result_accumulator
  import mul7_result_accumulator_pkg::*;
#(
  parameter int PROD_W    = DEF_PROD_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;
  logic             load;

  logic             beat, drain, slot_free, at_last, close_evt;
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;
  logic [ACC_W-1:0] fin_acc;
  logic [CNT_W-1:0] fin_cnt;
  logic             fin_ovf;

  sat_adder #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (ACC_W'(in_data)),
    .sum (add_sum),
    .sat (add_sat)
  );

  assign at_last   = (cnt == LAST);
  // Built from registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (state == S_RUN) && !(out_valid && at_last);
  assign beat      = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign slot_free = !out_valid || drain;

  // Frame totals including this cycle's beat. In S_HOLD beat is 0, so these
  // are simply the held totals.
  assign fin_acc   = beat ? add_sum : acc;
  assign fin_cnt   = cnt + CNT_W'(beat);
  assign fin_ovf   = ovf || (beat && add_sat);
  assign close_evt = (beat && at_last) || (flush && ((cnt != '0) || beat));

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    load     = 1'b0;
    case (state)
      S_RUN: begin
        if (close_evt) begin
          if (slot_free) begin
            load   = 1'b1;
            acc_nx = '0;
            cnt_nx = '0;
            ovf_nx = 1'b0;
          end else begin
            // Only a flush can close into a full slot: a closing beat needs
            // in_ready, which implies the slot is empty.
            acc_nx   = fin_acc;
            cnt_nx   = fin_cnt;
            ovf_nx   = fin_ovf;
            state_nx = S_HOLD;
          end
        end else if (beat) begin
          acc_nx = fin_acc;
          cnt_nx = fin_cnt;
          ovf_nx = fin_ovf;
        end
      end
      S_HOLD: begin
        if (slot_free) begin
          load     = 1'b1;
          acc_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
      if (load) begin
        out_valid <= 1'b1;
        out_sum   <= fin_acc;
        out_count <= fin_cnt;
        out_ovf   <= fin_ovf;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
